// File: rtl/seq_sub_nbit.sv
// Digit-serial subtractor: d = x - y - b_in, one k-bit chunk per clock, LSB first.
// Start/done handshake; d and b_out hold the last completed result.
module seq_sub_nbit #(
  parameter int unsigned n = 34,
  parameter int unsigned k = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         b_in,
  output logic [n-1:0] d,
  output logic         b_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned C  = (n + k - 1) / k;
  localparam int unsigned CW = $clog2(C + 1);
  localparam int unsigned PW = C * k;
  localparam int unsigned KW = k + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [n-1:0]  x_q, x_d, y_q, y_d;
  logic [n-1:0]  acc_q, acc_d;
  logic [n-1:0]  d_q, d_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic          b_out_q, b_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [PW-1:0] x_pad, y_pad;
  logic [k-1:0]  xc, yc;
  logic [KW-1:0] diff;
  logic [n-1:0]  acc_next;

  // Zero padding above bit n-1 keeps the borrow out of bit k equal to the
  // borrow out of bit n-1 on a short final chunk.
  assign x_pad = PW'(x_q);
  assign y_pad = PW'(y_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      d_q      <= d_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      b_out_q  <= b_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    d_d      = d_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    b_out_d  = b_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    xc       = '0;
    yc       = '0;

    for (int c = 0; c < int'(C); c++) begin
      if (idx_q == CW'(c)) begin
        xc = x_pad[c*k +: k];
        yc = y_pad[c*k +: k];
      end
    end

    diff = KW'(xc) - KW'(yc) - KW'(borrow_q);

    // Only the n real result bits of the current chunk are updated.
    acc_next = acc_q;
    for (int b = 0; b < int'(n); b++) begin
      if (idx_q == CW'(b / int'(k))) acc_next[b] = diff[b % int'(k)];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          x_d      = x;
          y_d      = y;
          borrow_d = b_in;
          idx_d    = '0;
          acc_d    = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        acc_d    = acc_next;
        borrow_d = diff[k];
        idx_d    = idx_q + CW'(1);
        if (idx_q == CW'(C - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          d_d     = acc_next;
          b_out_d = diff[k];
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d     = d_q;
  assign b_out = b_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_sub_nbit.sv
// Bench for seq_sub_nbit: default 34/8 instance plus a 16/16 single-chunk instance.
// Expected results come from a full-width reference subtraction held in a scoreboard queue.
module tb_seq_sub_nbit;

  logic clk, rst;

  logic        start_a, bin_a;
  logic [33:0] x_a, y_a, d_a;
  logic        bo_a, busy_a, done_a;

  logic        start_b, bin_b;
  logic [15:0] x_b, y_b, d_b;
  logic        bo_b, busy_b, done_b;

  typedef struct {
    logic [63:0] d;
    logic        bo;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  seq_sub_nbit #(.n(34), .k(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x(x_a), .y(y_a), .b_in(bin_a),
    .d(d_a), .b_out(bo_a), .busy(busy_a), .done(done_a)
  );

  seq_sub_nbit #(.n(16), .k(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x(x_b), .y(y_b), .b_in(bin_b),
    .d(d_b), .b_out(bo_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push34(input logic [33:0] xv, input logic [33:0] yv, input logic bv);
    logic [34:0] full;
    exp_t e;
    full = {1'b0, xv} - {1'b0, yv} - 35'(bv);
    e.d  = 64'(full[33:0]);
    e.bo = full[34];
    sb.push_back(e);
  endtask

  task automatic push16(input logic [15:0] xv, input logic [15:0] yv, input logic bv);
    logic [16:0] full;
    exp_t e;
    full = {1'b0, xv} - {1'b0, yv} - 17'(bv);
    e.d  = 64'(full[15:0]);
    e.bo = full[16];
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic [63:0] d_obs, input logic bo_obs,
                           output logic [63:0] d_exp);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    d_exp = '0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      d_exp = e.d;
      check({tag, "_d"}, d_obs, e.d);
      check({tag, "_bout"}, 64'(bo_obs), 64'(e.bo));
    end
  endtask

  // One operation on the 34/8 instance; noise re-pulses start with other operands mid-run.
  task automatic op_a(input string tag, input logic [33:0] xv, input logic [33:0] yv,
                      input logic bv, input logic noise);
    int lat, busy_cnt, extra_done;
    logic [63:0] d_exp;
    @(negedge clk);
    start_a = 1'b1; x_a = xv; y_a = yv; bin_a = bv;
    push34(xv, yv, bv);
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(busy_a), 64'd1);
    lat = 0;
    busy_cnt = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_a = noise && (i >= 1) && (i <= 3);
      if (start_a) begin
        x_a = 34'd1; y_a = 34'd9; bin_a = 1'b0;
      end
      if (done_a) begin
        lat = i;
        break;
      end
      busy_cnt += int'(busy_a);
    end
    start_a = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd5);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd5);
    check({tag, "_busy_at_done"}, 64'(busy_a), 64'd0);
    pop_check(tag, 64'(d_a), bo_a, d_exp);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      extra_done += int'(done_a);
    end
    check({tag, "_no_extra_done"}, 64'(extra_done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy_a), 64'd0);
    check({tag, "_d_held"}, 64'(d_a), d_exp);
  endtask

  initial begin
    int n_done;
    logic [63:0] d_exp;
    rst = 1'b1;
    start_a = 1'b0; x_a = '0; y_a = '0; bin_a = 1'b0;
    start_b = 1'b0; x_b = '0; y_b = '0; bin_b = 1'b0;
    #1;
    check("rst_a_d", 64'(d_a), 64'd0);
    check("rst_a_bout", 64'(bo_a), 64'd0);
    check("rst_a_busy", 64'(busy_a), 64'd0);
    check("rst_a_done", 64'(done_a), 64'd0);
    check("rst_b_d", 64'(d_b), 64'd0);
    check("rst_b_busy", 64'(busy_b), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op_a("small", 34'd5, 34'd3, 1'b0, 1'b0);
    op_a("ripple", 34'd0, 34'd1, 1'b0, 1'b0);
    op_a("ignore_start", 34'd10, 34'd4, 1'b0, 1'b1);
    check("ignore_start_value", 64'(d_a), 64'd6);
    op_a("cross32", 34'h1_0000_0000, 34'd1, 1'b0, 1'b0);
    op_a("eq_bin", 34'h2_0000_0000, 34'h2_0000_0000, 1'b1, 1'b0);

    // Abort mid-run with an asynchronous reset between E3 and E4.
    @(negedge clk);
    start_a = 1'b1; x_a = 34'h3_1234_5678; y_a = 34'h0_1111_1111; bin_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_d", 64'(d_a), 64'd0);
    check("abort_bout", 64'(bo_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_done", 64'(done_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_done += int'(done_a);
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_idle", 64'(busy_a), 64'd0);

    op_a("post_reset", 34'h2_AAAA_5555, 34'h1_5555_AAAA, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      logic [33:0] xr, yr;
      xr = 34'({$urandom(), $urandom()});
      yr = 34'({$urandom(), $urandom()});
      op_a($sformatf("rand%0d", r), xr, yr, 1'(($urandom() >> 3) & 1), 1'b0);
    end

    // Single-chunk instance: one-cycle latency and start accepted in the done cycle.
    @(negedge clk);
    start_b = 1'b1; x_b = 16'h8000; y_b = 16'h0001; bin_b = 1'b0;
    push16(16'h8000, 16'h0001, 1'b0);
    @(negedge clk);
    start_b = 1'b0;
    check("k16_busy", 64'(busy_b), 64'd1);
    check("k16_done_early", 64'(done_b), 64'd0);
    @(negedge clk);
    check("k16_done", 64'(done_b), 64'd1);
    check("k16_busy_at_done", 64'(busy_b), 64'd0);
    pop_check("k16_a", 64'(d_b), bo_b, d_exp);
    start_b = 1'b1; x_b = 16'h0000; y_b = 16'h0000; bin_b = 1'b1;
    push16(16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    start_b = 1'b0;
    check("k16_b2b_busy", 64'(busy_b), 64'd1);
    check("k16_b2b_done_low", 64'(done_b), 64'd0);
    check("k16_b2b_d_held", 64'(d_b), d_exp);
    @(negedge clk);
    check("k16_b2b_done", 64'(done_b), 64'd1);
    pop_check("k16_b", 64'(d_b), bo_b, d_exp);
    @(negedge clk);
    check("k16_done_fall", 64'(done_b), 64'd0);
    check("k16_d_held", 64'(d_b), d_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
